// File: rtl/contrast_event_arbiter.sv
// Serializes per-box PWM value-change events into one valid/ready stream, using round-robin grants.
// Optional feature: CONTRAST_EVT_COALESCE_EN (a repeated strobe on a pending box overwrites its value instead of flagging overrun).
module contrast_event_arbiter #(
    parameter int unsigned NUMBER_OF_BOXES = 2,
    parameter int unsigned PWM_REG_WIDTH   = 10,
    parameter int unsigned IDX_WIDTH       = 3
) (
    input  logic                                       clk_peri,
    input  logic                                       reset,
    input  logic [PWM_REG_WIDTH*NUMBER_OF_BOXES-1:0]   pwm_on_time,
    input  logic [NUMBER_OF_BOXES-1:0]                 pwm_value_changed,
    input  logic                                       evt_ready,
    output logic                                       evt_valid,
    output logic [IDX_WIDTH-1:0]                       evt_box,
    output logic [PWM_REG_WIDTH-1:0]                   evt_value,
    output logic [NUMBER_OF_BOXES-1:0]                 overrun,
    input  logic                                       clear_overrun
);

    localparam int unsigned NB = NUMBER_OF_BOXES;
    localparam int unsigned PW = PWM_REG_WIDTH;

    logic [PW-1:0]        r_val [NB];
    logic [NB-1:0]        r_pend;
    logic [IDX_WIDTH-1:0] r_rr_ptr;
    logic                 r_evt_valid;
    logic [IDX_WIDTH-1:0] r_evt_box;
    logic [PW-1:0]        r_evt_value;
    logic [NB-1:0]        r_overrun;

    logic                 w_out_free;
    logic                 w_found;
    logic                 w_grant;
    logic [IDX_WIDTH-1:0] w_grant_idx;
    logic [NB-1:0]        w_grant_oh;
    logic [PW-1:0]        w_grant_val;
    logic [NB-1:0]        w_ovr_set;

    assign w_out_free = !r_evt_valid || evt_ready;
    assign w_grant    = w_out_free && w_found;

    // First pending slot at or after rr_ptr, wrapping at the last box.
    always_comb begin
        int unsigned cand;
        cand        = 0;
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            cand = 32'(r_rr_ptr) + k;
            if (cand >= NB) begin
                cand = cand - NB;
            end
            for (int unsigned i = 0; i < NB; i++) begin
                if (!w_found && (cand == i) && r_pend[i]) begin
                    w_found     = 1'b1;
                    w_grant_idx = IDX_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        w_grant_oh  = '0;
        w_grant_val = '0;
        w_ovr_set   = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            w_grant_oh[i] = w_grant && (w_grant_idx == IDX_WIDTH'(i));
            if (w_grant_oh[i]) begin
                w_grant_val = r_val[i];
            end
`ifdef CONTRAST_EVT_COALESCE_EN
            w_ovr_set[i] = 1'b0;
`else
            w_ovr_set[i] = pwm_value_changed[i] && r_pend[i] && !w_grant_oh[i];
`endif
        end
    end

    // Capture slots: a strobe on a slot being granted in the same cycle re-arms it.
    always_ff @(posedge clk_peri or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                r_val[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (pwm_value_changed[i]) begin
                    if (!r_pend[i] || w_grant_oh[i]) begin
                        r_val[i]  <= pwm_on_time[PW*i +: PW];
                        r_pend[i] <= 1'b1;
                    end else begin
`ifdef CONTRAST_EVT_COALESCE_EN
                        r_val[i]  <= pwm_on_time[PW*i +: PW];
`endif
                    end
                end else if (w_grant_oh[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Output register, round-robin pointer and sticky overrun flags.
    always_ff @(posedge clk_peri or posedge reset) begin
        if (reset) begin
            r_evt_valid <= 1'b0;
            r_evt_box   <= '0;
            r_evt_value <= '0;
            r_rr_ptr    <= '0;
            r_overrun   <= '0;
        end else begin
            if (w_grant) begin
                r_evt_valid <= 1'b1;
                r_evt_box   <= w_grant_idx;
                r_evt_value <= w_grant_val;
                r_rr_ptr    <= (w_grant_idx == IDX_WIDTH'(NB - 1)) ? '0 : w_grant_idx + IDX_WIDTH'(1);
            end else if (w_out_free) begin
                r_evt_valid <= 1'b0;
            end
            r_overrun <= (clear_overrun ? '0 : r_overrun) | w_ovr_set;
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_box   = r_evt_box;
    assign evt_value = r_evt_value;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_contrast_event_arbiter.sv
// Directed bench for contrast_event_arbiter (2 boxes, 10-bit values); expectations follow CONTRAST_EVT_COALESCE_EN.
module tb_contrast_event_arbiter;

    logic        clk_peri;
    logic        reset;
    logic [19:0] pwm_on_time;
    logic [1:0]  pwm_value_changed;
    logic        evt_ready;
    logic        evt_valid;
    logic [2:0]  evt_box;
    logic [9:0]  evt_value;
    logic [1:0]  overrun;
    logic        clear_overrun;

    int n_cmp;
    int n_fail;

    wire [13:0] w_obs = {evt_valid, evt_box, evt_value};

    contrast_event_arbiter #(
        .NUMBER_OF_BOXES(2),
        .PWM_REG_WIDTH  (10),
        .IDX_WIDTH      (3)
    ) dut (
        .clk_peri         (clk_peri),
        .reset            (reset),
        .pwm_on_time      (pwm_on_time),
        .pwm_value_changed(pwm_value_changed),
        .evt_ready        (evt_ready),
        .evt_valid        (evt_valid),
        .evt_box          (evt_box),
        .evt_value        (evt_value),
        .overrun          (overrun),
        .clear_overrun    (clear_overrun)
    );

    initial clk_peri = 1'b0;
    always #5 clk_peri = ~clk_peri;

    function automatic logic [13:0] ev(input logic v, input logic [2:0] b, input logic [9:0] val);
        return {v, b, val};
    endfunction

    task automatic tick();
        @(posedge clk_peri);
        #1;
    endtask

    task automatic strobe(input logic [1:0] mask, input logic [9:0] v0, input logic [9:0] v1);
        pwm_on_time       = {v1, v0};
        pwm_value_changed = mask;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #23;
        n_cmp++;
        if (w_obs !== 14'h0 || overrun !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hold got evt=%h ovr=%b want evt=0000 ovr=00", w_obs, overrun);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (w_obs !== 14'h0 || overrun !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release got evt=%h ovr=%b want evt=0000 ovr=00", w_obs, overrun);
        end
    endtask

    task automatic test_single();
        evt_ready = 1'b1;
        strobe(2'b10, 10'h000, 10'h155);
        tick();
        strobe(2'b00, 10'h000, 10'h000);
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency1 got valid=%b want 0", evt_valid);
        end
        tick();
        n_cmp++;
        if (w_obs !== ev(1'b1, 3'd1, 10'h155)) begin
            n_fail++;
            $display("FAIL single_evt got %h want %h", w_obs, ev(1'b1, 3'd1, 10'h155));
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain got valid=%b want 0", evt_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            evt_ready = 1'b1;
            strobe(2'b11, 10'h010, 10'h020);
            tick();
            strobe(2'b00, 10'h000, 10'h000);
            tick();
            n_cmp++;
            if (w_obs !== ev(1'b1, 3'd0, 10'h010)) begin
                n_fail++;
                $display("FAIL b2b_first_r%0d got %h want %h", r, w_obs, ev(1'b1, 3'd0, 10'h010));
            end
            tick();
            n_cmp++;
            if (w_obs !== ev(1'b1, 3'd1, 10'h020)) begin
                n_fail++;
                $display("FAIL b2b_second_r%0d got %h want %h", r, w_obs, ev(1'b1, 3'd1, 10'h020));
            end
            tick();
            n_cmp++;
            if (evt_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_drain_r%0d got valid=%b want 0", r, evt_valid);
            end
        end
    endtask

    task automatic test_overrun();
        logic [1:0] exp_ovr;
        logic [9:0] exp_val;
`ifdef CONTRAST_EVT_COALESCE_EN
        exp_ovr = 2'b00;
        exp_val = 10'h3FF;
`else
        exp_ovr = 2'b01;
        exp_val = 10'h111;
`endif
        evt_ready = 1'b0;
        strobe(2'b10, 10'h000, 10'h0AA);
        tick();
        strobe(2'b00, 10'h000, 10'h000);
        tick();
        strobe(2'b01, 10'h111, 10'h000);
        tick();
        strobe(2'b01, 10'h3FF, 10'h000);
        tick();
        strobe(2'b00, 10'h000, 10'h000);
        n_cmp++;
        if (overrun !== exp_ovr) begin
            n_fail++;
            $display("FAIL ovr_flag got %b want %b", overrun, exp_ovr);
        end
        n_cmp++;
        if (w_obs !== ev(1'b1, 3'd1, 10'h0AA)) begin
            n_fail++;
            $display("FAIL ovr_stall_hold got %h want %h", w_obs, ev(1'b1, 3'd1, 10'h0AA));
        end
        evt_ready = 1'b1;
        tick();
        n_cmp++;
        if (w_obs !== ev(1'b1, 3'd0, exp_val)) begin
            n_fail++;
            $display("FAIL ovr_delivered got %h want %h", w_obs, ev(1'b1, 3'd0, exp_val));
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_drain got valid=%b want 0", evt_valid);
        end
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        n_cmp++;
        if (overrun !== 2'b00) begin
            n_fail++;
            $display("FAIL ovr_clear got %b want 00", overrun);
        end
    endtask

    task automatic test_grant_with_strobe();
        evt_ready = 1'b0;
        strobe(2'b10, 10'h000, 10'h0BB);
        tick();
        strobe(2'b00, 10'h000, 10'h000);
        tick();
        strobe(2'b01, 10'h0CC, 10'h000);
        tick();
        evt_ready = 1'b1;
        strobe(2'b01, 10'h001, 10'h000);
        tick();
        strobe(2'b00, 10'h000, 10'h000);
        n_cmp++;
        if (w_obs !== ev(1'b1, 3'd0, 10'h0CC)) begin
            n_fail++;
            $display("FAIL gs_old got %h want %h", w_obs, ev(1'b1, 3'd0, 10'h0CC));
        end
        tick();
        n_cmp++;
        if (w_obs !== ev(1'b1, 3'd0, 10'h001)) begin
            n_fail++;
            $display("FAIL gs_new got %h want %h", w_obs, ev(1'b1, 3'd0, 10'h001));
        end
        n_cmp++;
        if (overrun !== 2'b00) begin
            n_fail++;
            $display("FAIL gs_ovr got %b want 00", overrun);
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gs_drain got valid=%b want 0", evt_valid);
        end
    endtask

    task automatic test_clear_vs_set();
        logic [1:0] exp_ovr;
        logic [9:0] exp_val;
`ifdef CONTRAST_EVT_COALESCE_EN
        exp_ovr = 2'b00;
        exp_val = 10'h070;
`else
        exp_ovr = 2'b10;
        exp_val = 10'h060;
`endif
        evt_ready = 1'b0;
        strobe(2'b01, 10'h050, 10'h000);
        tick();
        strobe(2'b00, 10'h000, 10'h000);
        tick();
        strobe(2'b10, 10'h000, 10'h060);
        tick();
        strobe(2'b10, 10'h000, 10'h070);
        clear_overrun = 1'b1;
        tick();
        strobe(2'b00, 10'h000, 10'h000);
        n_cmp++;
        if (overrun !== exp_ovr) begin
            n_fail++;
            $display("FAIL cs_set_wins got %b want %b", overrun, exp_ovr);
        end
        tick();
        clear_overrun = 1'b0;
        n_cmp++;
        if (overrun !== 2'b00) begin
            n_fail++;
            $display("FAIL cs_clear got %b want 00", overrun);
        end
        evt_ready = 1'b1;
        tick();
        n_cmp++;
        if (w_obs !== ev(1'b1, 3'd1, exp_val)) begin
            n_fail++;
            $display("FAIL cs_delivered got %h want %h", w_obs, ev(1'b1, 3'd1, exp_val));
        end
        tick();
    endtask

    task automatic test_async_reset();
        evt_ready = 1'b0;
        strobe(2'b01, 10'h123, 10'h000);
        tick();
        strobe(2'b00, 10'h000, 10'h000);
        tick();
        strobe(2'b10, 10'h000, 10'h056);
        tick();
        strobe(2'b00, 10'h000, 10'h000);
        n_cmp++;
        if (w_obs !== ev(1'b1, 3'd0, 10'h123)) begin
            n_fail++;
            $display("FAIL ar_pre got %h want %h", w_obs, ev(1'b1, 3'd0, 10'h123));
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (w_obs !== 14'h0) begin
            n_fail++;
            $display("FAIL ar_immediate got %h want 0000", w_obs);
        end
        #10;
        reset     = 1'b0;
        evt_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (evt_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ar_no_stale_c%0d got valid=%b box=%0d val=%h want valid=0", c, evt_valid, evt_box, evt_value);
            end
        end
    endtask

    initial begin
        n_cmp             = 0;
        n_fail            = 0;
        pwm_on_time       = '0;
        pwm_value_changed = '0;
        evt_ready         = 1'b0;
        clear_overrun     = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_grant_with_strobe();
        test_clear_vs_set();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
